alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Second-generation configurable ALU for the register-file/system-controller datapath. It generalises operand and result widths and adds a valid/ready handshake on both sides. Status flags are produced alongside each result. Division and modulo run on an iterative, multi-cycle divider, so throughput is one operation per cycle except for divide operations.

Parameters:
OPER_WIDTH, 8, width of unsigned operands A and B (legal range 4..32).
OUT_WIDTH, 16, result width; must be >= 2*OPER_WIDTH so a full product fits.

Ports:
CLK       in   1           single system clock, rising-edge.
RST       in   1           asynchronous, active-high reset.
A         in   OPER_WIDTH  operand A, unsigned.
B         in   OPER_WIDTH  operand B, unsigned.
ALU_FUN   in   4           opcode, sampled on accept.
IN_VALID  in   1           request valid.
IN_READY  out  1           block can accept a request this cycle.
ALU_OUT   out  OUT_WIDTH   registered result.
CARRY     out  1           ADD carry-out or SUB borrow; 0 for every other opcode.
ZERO      out  1           ALU_OUT == 0.
DIV_ZERO  out  1           DIV/MOD issued with B == 0.
OUT_VALID out  1           result and flags valid.
OUT_READY in   1           consumer takes the result.

Behaviour:
- Reset (RST=1, async): ALU_OUT=0, CARRY=0, ZERO=0, DIV_ZERO=0, OUT_VALID=0, FSM=IDLE, divider cleared. IN_READY=1 from the first edge after RST deasserts.
- Accept: occurs on a rising edge with IN_VALID && IN_READY. A, B and ALU_FUN are captured only at accept.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). Combinational; it never depends on IN_VALID.
- Output handshake: the result register holds while OUT_VALID && !OUT_READY.
- OUT_VALID clears on the OUT_READY edge unless a new result loads on that same edge. Loading a new result while a result is held is impossible by construction.
- Opcodes: all results zero-extended to OUT_WIDTH.
  - 0000 ADD: A+B. CARRY = bit OPER_WIDTH of the sum; result keeps OPER_WIDTH+1 bits.
  - 0001 SUB: (A-B) mod 2^OPER_WIDTH. CARRY = (A<B).
  - 0010 MUL: full A*B.
  - 0011 DIV: quotient.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR: each on OPER_WIDTH bits.
  - 1010 EQ: 1 if A==B, else 0.
  - 1011 GT: 2 if A>B, else 0.
  - 1100 LT: 3 if A<B, else 0.
  - 1101 SHR: A>>1.
  - 1110 SHL: A<<1, keeping bit OPER_WIDTH.
  - 1111 MOD: remainder.
- Single-cycle ops: result, flags and OUT_VALID=1 appear at the edge following accept. Back-to-back accepts are allowed when OUT_READY=1 (throughput 1/cycle).
- FSM states: IDLE, DIV, DONE.
  - IDLE --accept DIV/MOD with B!=0--> DIV.
  - DIV stays for exactly OPER_WIDTH edges (one restoring-division bit per edge), then goes to DONE.
  - DONE loads the quotient (DIV) or remainder (MOD) into ALU_OUT, sets OUT_VALID=1, and returns to IDLE on the same edge.
  - Net effect: OUT_VALID rises OPER_WIDTH+1 edges after accept. IN_READY=0 throughout DIV and DONE.
- DIV/MOD with B==0: no iteration. Single-cycle latency; ALU_OUT = all ones (OUT_WIDTH bits); DIV_ZERO=1.
- DIV_ZERO is 0 for every other result.
- ZERO is computed from the value being loaded, so it is registered together with ALU_OUT.
- Flags load only when a result loads.
- Reset mid-divide: aborts immediately. No OUT_VALID pulse is produced for the aborted op.
- Input changes while busy are ignored: IN_READY=0, so no accept can occur.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (ALU_ADD..ALU_MOD, 4-bit);
  - FSM state encoding (IDLE, DIV, DONE);
  - compare result constants (EQ=1, GT=2, LT=3).
- Sub-module alu_div_iter(OPER_WIDTH):
  - inputs: start, dividend, divisor;
  - outputs: quotient, remainder, done;
  - one bit per cycle; asynchronous active-high reset on RST.
- Top holds: opcode mux, result and flag registers, FSM, handshake logic.

Test Plan (OPER_WIDTH=8, OUT_WIDTH=16):
1. ADD A=200 B=100 with OUT_READY=1 -> next edge ALU_OUT=0x012C, CARRY=1, ZERO=0, OUT_VALID=1.
2. MUL A=255 B=255, then SUB A=5 B=9 on consecutive cycles -> ALU_OUT=0xFE01, then 0x00FC with CARRY=1; IN_READY stays 1 throughout.
3. DIV A=200 B=7 -> IN_READY=0 for 9 cycles; ALU_OUT=28 with OUT_VALID exactly 9 edges after accept. Then MOD with the same operands -> ALU_OUT=4.
4. DIV A=50 B=0 -> after 1 edge ALU_OUT=0xFFFF, DIV_ZERO=1, OUT_VALID=1. The next op, AND 0xF0&0x0F, gives ALU_OUT=0, ZERO=1, DIV_ZERO=0.
5. Backpressure: OUT_READY=0 after XOR A=0xAA B=0x55 -> ALU_OUT=0x00FF held, IN_READY=0, pending EQ not accepted. Raise OUT_READY -> EQ accepted and returns 1; no result lost or duplicated.
6. Assert RST on the 4th DIV cycle -> all outputs 0 asynchronously. After release, IN_READY=1; a fresh ADD 1+1 returns 2 with no stale OUT_VALID.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM state encoding
// and the constants returned by the compare operations.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NAND = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_XNOR = 4'b1001;
    localparam logic [3:0] ALU_EQ   = 4'b1010;
    localparam logic [3:0] ALU_GT   = 4'b1011;
    localparam logic [3:0] ALU_LT   = 4'b1100;
    localparam logic [3:0] ALU_SHR  = 4'b1101;
    localparam logic [3:0] ALU_SHL  = 4'b1110;
    localparam logic [3:0] ALU_MOD  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;
    localparam logic [1:0] CMP_LT = 2'd3;

    function automatic logic is_div_op(input logic [3:0] fun);
        return (fun == ALU_DIV) || (fun == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider producing one quotient bit per clock. Operands are captured
// on start; quotient and remainder are final on the edge where done is high.
module alu_div_iter
    import alu_pkg::*;
#(
    parameter int OPER_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [OPER_WIDTH-1:0] dividend,
    input  logic [OPER_WIDTH-1:0] divisor,
    output logic [OPER_WIDTH-1:0] quotient,
    output logic [OPER_WIDTH-1:0] remainder,
    output logic                  done
);

    localparam int            CW   = $clog2(OPER_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(OPER_WIDTH - 1);

    logic [OPER_WIDTH-1:0] r_rem;
    logic [OPER_WIDTH-1:0] r_quo;
    logic [OPER_WIDTH-1:0] r_dvs;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;

    logic [OPER_WIDTH:0]   w_trial;
    logic [OPER_WIDTH:0]   w_diff;
    logic                  w_ge;

    // The dividend shifts out of r_quo MSB-first while quotient bits shift in.
    assign w_trial = {r_rem, r_quo[OPER_WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= '0;
            r_quo  <= dividend;
            r_dvs  <= divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff[OPER_WIDTH-1:0] : w_trial[OPER_WIDTH-1:0];
            r_quo  <= {r_quo[OPER_WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    // High during the cycle whose closing edge commits the last quotient bit.
    assign done      = r_busy && (r_cnt == LAST);
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/alu_mc.sv
// Configurable ALU with valid/ready on both sides. Single-cycle opcodes load
// the result register on accept; DIV/MOD with a non-zero divisor iterate.
module alu_mc
    import alu_pkg::*;
#(
    parameter int OPER_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [OPER_WIDTH-1:0] A,
    input  logic [OPER_WIDTH-1:0] B,
    input  logic [3:0]            ALU_FUN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [OUT_WIDTH-1:0]  ALU_OUT,
    output logic                  CARRY,
    output logic                  ZERO,
    output logic                  DIV_ZERO,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    alu_state_e r_state;
    alu_state_e w_next_state;

    logic                  r_run;
    logic                  r_is_mod;
    logic [OUT_WIDTH-1:0]  r_out;
    logic                  r_carry;
    logic                  r_zero;
    logic                  r_dz;
    logic                  r_valid;

    logic                  w_accept;
    logic                  w_div_iter;
    logic                  w_load_now;
    logic                  w_idle;
    logic                  w_load_div;
    logic                  w_load;

    logic [OPER_WIDTH:0]     w_sum;
    logic [2*OPER_WIDTH-1:0] w_prod;
    logic [OUT_WIDTH-1:0]    w_res;
    logic                    w_carry;
    logic                    w_dz;

    logic [OPER_WIDTH-1:0] w_quo;
    logic [OPER_WIDTH-1:0] w_rem;
    logic                  w_div_done;
    logic [OUT_WIDTH-1:0]  w_div_val;
    logic [OUT_WIDTH-1:0]  w_load_val;

    // r_run keeps IN_READY low until the first edge after reset is released.
    assign IN_READY   = r_run && w_idle && (!r_valid || OUT_READY);
    assign w_accept   = IN_VALID && IN_READY;
    assign w_div_iter = w_accept && is_div_op(ALU_FUN) && (B != '0);
    assign w_load_now = w_accept && !w_div_iter;

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_prod = (2*OPER_WIDTH)'(A) * (2*OPER_WIDTH)'(B);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_dz    = 1'b0;
        case (ALU_FUN)
            ALU_ADD: begin
                w_res[OPER_WIDTH:0] = w_sum;
                w_carry             = w_sum[OPER_WIDTH];
            end
            ALU_SUB: begin
                w_res[OPER_WIDTH-1:0] = A - B;
                w_carry               = (A < B);
            end
            ALU_MUL:  w_res[2*OPER_WIDTH-1:0] = w_prod;
            // Only reaches the result register when B is zero.
            ALU_DIV, ALU_MOD: begin
                w_res = '1;
                w_dz  = 1'b1;
            end
            ALU_AND:  w_res[OPER_WIDTH-1:0] = A & B;
            ALU_OR:   w_res[OPER_WIDTH-1:0] = A | B;
            ALU_NAND: w_res[OPER_WIDTH-1:0] = ~(A & B);
            ALU_NOR:  w_res[OPER_WIDTH-1:0] = ~(A | B);
            ALU_XOR:  w_res[OPER_WIDTH-1:0] = A ^ B;
            ALU_XNOR: w_res[OPER_WIDTH-1:0] = ~(A ^ B);
            ALU_EQ:   w_res[1:0] = (A == B) ? CMP_EQ : 2'b00;
            ALU_GT:   w_res[1:0] = (A > B)  ? CMP_GT : 2'b00;
            ALU_LT:   w_res[1:0] = (A < B)  ? CMP_LT : 2'b00;
            ALU_SHR:  w_res[OPER_WIDTH-1:0] = A >> 1;
            ALU_SHL:  w_res[OPER_WIDTH:0]   = {A, 1'b0};
            default: ;
        endcase
    end

    alu_div_iter #(
        .OPER_WIDTH(OPER_WIDTH)
    ) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .start    (w_div_iter),
        .dividend (A),
        .divisor  (B),
        .quotient (w_quo),
        .remainder(w_rem),
        .done     (w_div_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_div_iter) w_next_state = DIV;
            DIV:     if (w_div_done) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_idle     = (r_state == IDLE);
        w_load_div = (r_state == DONE);
    end

    always_comb begin
        w_div_val                   = '0;
        w_div_val[OPER_WIDTH-1:0]   = r_is_mod ? w_rem : w_quo;
    end

    assign w_load     = w_load_now || w_load_div;
    assign w_load_val = w_load_div ? w_div_val : w_res;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_run    <= 1'b0;
            r_is_mod <= 1'b0;
            r_out    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_dz     <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_div_iter) begin
                r_is_mod <= (ALU_FUN == ALU_MOD);
            end
            if (w_load) begin
                r_out   <= w_load_val;
                r_zero  <= (w_load_val == '0);
                r_carry <= w_load_div ? 1'b0 : w_carry;
                r_dz    <= w_load_div ? 1'b0 : w_dz;
                r_valid <= 1'b1;
            end else if (OUT_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ALU_OUT   = r_out;
    assign CARRY     = r_carry;
    assign ZERO      = r_zero;
    assign DIV_ZERO  = r_dz;
    assign OUT_VALID = r_valid;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int OW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [3:0]    ALU_FUN = 4'd0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [OW-1:0] ALU_OUT;
    logic          CARRY;
    logic          ZERO;
    logic          DIV_ZERO;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    alu_mc #(.OPER_WIDTH(W), .OUT_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_OUT(ALU_OUT),
        .CARRY(CARRY), .ZERO(ZERO), .DIV_ZERO(DIV_ZERO),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    typedef struct {
        logic [3:0]    fun;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] res;
        logic          carry;
        logic          zero;
        logic          dz;
    } vec_t;

    typedef struct {
        longint res;
        bit     carry;
        bit     dz;
    } exp_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] f, input int a, input int b,
                                input int res, input bit c, input bit z, input bit dz);
        vec_t v;
        v.fun = f; v.a = W'(a); v.b = W'(b); v.res = OW'(res);
        v.carry = c; v.zero = z; v.dz = dz;
        return v;
    endfunction

    // Reference behaviour written straight from the opcode definitions.
    function automatic exp_t ref_op(input logic [3:0] f, input longint a, input longint b);
        exp_t   e;
        longint m = (longint'(1) << W) - 1;
        e.res = 0; e.carry = 0; e.dz = 0;
        case (f)
            ALU_ADD:  begin e.res = a + b; e.carry = (a + b) > m; end
            ALU_SUB:  begin e.res = (a - b) & m; e.carry = (a < b); end
            ALU_MUL:  e.res = a * b;
            ALU_DIV:  if (b == 0) begin e.res = (longint'(1) << OW) - 1; e.dz = 1; end
                      else e.res = a / b;
            ALU_MOD:  if (b == 0) begin e.res = (longint'(1) << OW) - 1; e.dz = 1; end
                      else e.res = a % b;
            ALU_AND:  e.res = a & b;
            ALU_OR:   e.res = a | b;
            ALU_NAND: e.res = (~(a & b)) & m;
            ALU_NOR:  e.res = (~(a | b)) & m;
            ALU_XOR:  e.res = a ^ b;
            ALU_XNOR: e.res = (~(a ^ b)) & m;
            ALU_EQ:   e.res = (a == b) ? 1 : 0;
            ALU_GT:   e.res = (a > b) ? 2 : 0;
            ALU_LT:   e.res = (a < b) ? 3 : 0;
            ALU_SHR:  e.res = a >> 1;
            ALU_SHL:  e.res = a << 1;
            default:  e.res = 0;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        n = 0;
        while (IN_READY !== 1'b1 && n < 40) begin tick(); n++; end
        chk($sformatf("v%0d_in_ready", idx), 32'(IN_READY), 32'd1);
        A = v.a; B = v.b; ALU_FUN = v.fun; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        n = 0;
        while (OUT_VALID !== 1'b1 && n < 40) begin tick(); n++; end
        chk($sformatf("v%0d_out_valid", idx), 32'(OUT_VALID), 32'd1);
        chk($sformatf("v%0d_alu_out", idx), 32'(ALU_OUT), 32'(v.res));
        chk($sformatf("v%0d_carry", idx), 32'(CARRY), 32'(v.carry));
        chk($sformatf("v%0d_zero", idx), 32'(ZERO), 32'(v.zero));
        chk($sformatf("v%0d_div_zero", idx), 32'(DIV_ZERO), 32'(v.dz));
        $display("vec %0d fun=%0d a=%0d b=%0d -> out=0x%0h c=%0b z=%0b dz=%0b",
                 idx, v.fun, v.a, v.b, ALU_OUT, CARRY, ZERO, DIV_ZERO);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t   m_exp, m_pend, e;
        bit     m_valid, m_rdy, iv, ordy;
        int     m_busy;
        logic [3:0]   f;
        logic [W-1:0] ra, rb;

        vecs.push_back(mk(ALU_ADD,  200, 100, 16'h012C, 1, 0, 0));
        vecs.push_back(mk(ALU_ADD,  255,   1, 16'h0100, 1, 0, 0));
        vecs.push_back(mk(ALU_SUB,    5,   5, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(ALU_MUL,  255, 255, 16'hFE01, 0, 0, 0));
        vecs.push_back(mk(ALU_DIV,  200,   7, 28,       0, 0, 0));
        vecs.push_back(mk(ALU_MOD,  200,   7, 4,        0, 0, 0));
        vecs.push_back(mk(ALU_DIV,    7, 200, 0,        0, 1, 0));
        vecs.push_back(mk(ALU_MOD,    7, 200, 7,        0, 0, 0));
        vecs.push_back(mk(ALU_DIV,  255,   1, 255,      0, 0, 0));
        vecs.push_back(mk(ALU_DIV,   50,   0, 16'hFFFF, 0, 0, 1));
        vecs.push_back(mk(ALU_AND, 8'hF0, 8'h0F, 0,     0, 1, 0));
        vecs.push_back(mk(ALU_MOD,   50,   0, 16'hFFFF, 0, 0, 1));
        vecs.push_back(mk(ALU_OR,  8'hF0, 8'h0F, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(ALU_NAND, 8'hF0, 8'hFF, 8'h0F, 0, 0, 0));
        vecs.push_back(mk(ALU_NOR,    0,   0, 8'hFF,    0, 0, 0));
        vecs.push_back(mk(ALU_XNOR, 8'hAA, 8'h55, 0,    0, 1, 0));
        vecs.push_back(mk(ALU_EQ,     3,   4, 0,        0, 1, 0));
        vecs.push_back(mk(ALU_GT,     9,   3, 2,        0, 0, 0));
        vecs.push_back(mk(ALU_LT,     3,   9, 3,        0, 0, 0));
        vecs.push_back(mk(ALU_SHR, 8'h81,  0, 8'h40,    0, 0, 0));
        vecs.push_back(mk(ALU_SHL, 8'h81,  0, 16'h0102, 0, 0, 0));

        // Reset state
        #2;
        chk("rst_alu_out", 32'(ALU_OUT), 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_carry", 32'(CARRY), 32'd0);
        chk("rst_zero", 32'(ZERO), 32'd0);
        chk("rst_div_zero", 32'(DIV_ZERO), 32'd0);
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(IN_READY), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);
        tick();

        // Back-to-back MUL then SUB
        A = 8'd255; B = 8'd255; ALU_FUN = ALU_MUL; IN_VALID = 1'b1; #1;
        chk("b2b_ready0", 32'(IN_READY), 32'd1);
        tick();
        chk("b2b_mul_out", 32'(ALU_OUT), 32'hFE01);
        chk("b2b_ready1", 32'(IN_READY), 32'd1);
        A = 8'd5; B = 8'd9; ALU_FUN = ALU_SUB;
        tick();
        IN_VALID = 1'b0;
        chk("b2b_sub_out", 32'(ALU_OUT), 32'h00FC);
        chk("b2b_sub_carry", 32'(CARRY), 32'd1);
        chk("b2b_sub_valid", 32'(OUT_VALID), 32'd1);
        $display("seq b2b: mul then sub -> out=0x%0h carry=%0b", ALU_OUT, CARRY);
        tick();

        // Divide latency: busy for OPER_WIDTH+1 cycles, result on edge OPER_WIDTH+1
        A = 8'd200; B = 8'd7; ALU_FUN = ALU_DIV; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        for (int k = 0; k < W + 1; k++) begin
            chk($sformatf("div_busy_ready_e%0d", k), 32'(IN_READY), 32'd0);
            chk($sformatf("div_busy_valid_e%0d", k), 32'(OUT_VALID), 32'd0);
            tick();
        end
        chk("div_lat_valid", 32'(OUT_VALID), 32'd1);
        chk("div_lat_out", 32'(ALU_OUT), 32'd28);
        chk("div_lat_ready", 32'(IN_READY), 32'd1);
        $display("seq div latency: out=%0d valid=%0b", ALU_OUT, OUT_VALID);
        tick();

        // Divide by zero is single cycle
        A = 8'd50; B = 8'd0; ALU_FUN = ALU_DIV; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        chk("dz_valid", 32'(OUT_VALID), 32'd1);
        chk("dz_out", 32'(ALU_OUT), 32'hFFFF);
        chk("dz_flag", 32'(DIV_ZERO), 32'd1);
        $display("seq div by zero: out=0x%0h dz=%0b", ALU_OUT, DIV_ZERO);
        tick();

        // Backpressure: held XOR result, pending EQ must wait
        OUT_READY = 1'b0;
        A = 8'hAA; B = 8'h55; ALU_FUN = ALU_XOR; IN_VALID = 1'b1;
        tick();
        A = 8'd3; B = 8'd3; ALU_FUN = ALU_EQ;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_valid_%0d", k), 32'(OUT_VALID), 32'd1);
            chk($sformatf("bp_out_%0d", k), 32'(ALU_OUT), 32'h00FF);
            chk($sformatf("bp_ready_%0d", k), 32'(IN_READY), 32'd0);
            tick();
        end
        OUT_READY = 1'b1; #1;
        chk("bp_release_ready", 32'(IN_READY), 32'd1);
        tick();
        IN_VALID = 1'b0;
        chk("bp_eq_valid", 32'(OUT_VALID), 32'd1);
        chk("bp_eq_out", 32'(ALU_OUT), 32'd1);
        tick();
        chk("bp_no_dup", 32'(OUT_VALID), 32'd0);
        $display("seq backpressure: eq out=%0d, valid after drain=%0b", ALU_OUT, OUT_VALID);

        // Reset during the 4th divide cycle
        A = 8'd200; B = 8'd7; ALU_FUN = ALU_DIV; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick(); tick(); tick();
        #2 RST = 1'b1; #1;
        chk("mid_rst_out", 32'(ALU_OUT), 32'd0);
        chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
        chk("mid_rst_zero", 32'(ZERO), 32'd0);
        chk("mid_rst_carry", 32'(CARRY), 32'd0);
        chk("mid_rst_dz", 32'(DIV_ZERO), 32'd0);
        chk("mid_rst_ready", 32'(IN_READY), 32'd0);
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("after_rst_ready", 32'(IN_READY), 32'd1);
        for (int k = 0; k < W + 3; k++) begin
            chk($sformatf("after_rst_no_stale_%0d", k), 32'(OUT_VALID), 32'd0);
            tick();
        end
        run_vec(mk(ALU_ADD, 1, 1, 2, 0, 0, 0), 99);
        tick(); tick();

        // Random traffic against the behavioural model
        m_valid = 0; m_busy = 0;
        m_exp.res = 0; m_exp.carry = 0; m_exp.dz = 0;
        m_pend = m_exp;
        for (int c = 0; c < 1500; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            f    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) f = ($urandom_range(0, 1) != 0) ? ALU_DIV : ALU_MOD;
            ra   = W'($urandom);
            rb   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 9) == 0) ra = '0;
            A = ra; B = rb; ALU_FUN = f; IN_VALID = iv; OUT_READY = ordy;
            m_rdy = (m_busy == 0) && (!m_valid || ordy);
            #1;
            chk($sformatf("rnd%0d_in_ready", c), 32'(IN_READY), 32'(m_rdy));
            @(posedge CLK);
            if (m_valid && ordy) m_valid = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin m_valid = 1; m_exp = m_pend; end
            end
            if (iv && m_rdy) begin
                e = ref_op(f, longint'(ra), longint'(rb));
                if ((f == ALU_DIV || f == ALU_MOD) && rb != 0) begin
                    m_busy = W + 1; m_pend = e;
                end else begin
                    m_valid = 1; m_exp = e;
                end
            end
            #1;
            chk($sformatf("rnd%0d_out_valid", c), 32'(OUT_VALID), 32'(m_valid));
            if (m_valid) begin
                chk($sformatf("rnd%0d_alu_out", c), 32'(ALU_OUT), 32'(m_exp.res));
                chk($sformatf("rnd%0d_carry", c), 32'(CARRY), 32'(m_exp.carry));
                chk($sformatf("rnd%0d_zero", c), 32'(ZERO), 32'(m_exp.res == 0));
                chk($sformatf("rnd%0d_div_zero", c), 32'(DIV_ZERO), 32'(m_exp.dz));
            end
            if (iv && m_rdy)
                $display("rnd %0d accept fun=%0d a=%0d b=%0d", c, f, ra, rb);
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
